mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares the single memory32 data port between the processor's instruction-fetch path and its load/store path.
- Sits between the core's fetch/memRead/memWrite method interfaces and the memory instance.
- Allows one outstanding transaction at a time.
- Accepts a request by valid/ready handshake, drives one memory access, waits a fixed latency, and returns the registered result to the granted requester.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 1, cycles from mem_en to valid mem_rdata (legal range 1..7)
STARVE_MAX, 4, consecutive lost arbitrations after which fetch wins (fixed-priority mode only, 1..15)

Ports:
CLK  input  1  clock
RESET  input  1  reset; asynchronous, active-high
fetch_req_valid  input  1  fetch request
fetch_req_addr  input  ADDR_W  fetch address
fetch_req_ready  output  1  fetch accepted this cycle
fetch_res_valid  output  1  fetch data valid (1-cycle pulse)
fetch_res_data  output  DATA_W  fetched instruction
data_req_valid  input  1  load/store request
data_req_write  input  1  1=store, 0=load
data_req_addr  input  ADDR_W  load/store address
data_req_wdata  input  DATA_W  store data
data_req_ready  output  1  load/store accepted this cycle
data_res_valid  output  1  load data / store ack (1-cycle pulse)
data_res_rdata  output  DATA_W  load data; 0 for stores
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data

Behaviour:

Reset:
- All outputs are 0 and state is IDLE.
- Starvation counter and round-robin pointer are 0.
- RESET is asynchronous and active-high.
- A reset mid-transaction discards the transaction: no res_valid pulse follows, and ready may assert in the first cycle after RESET deasserts.

FSM states:
- IDLE: arbitrate; *_req_ready is high only for the winner, and only when its valid is high. Ready depends combinationally on valid and state. A handshake in cycle T latches id, write, addr and wdata, then goes to ISSUE.
- ISSUE (T+1): mem_en=1 and mem_addr=latched addr. mem_we and mem_wdata are set only for stores. Load the latency counter with MEM_LAT, then go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0 (cycle T+1+MEM_LAT), capture mem_rdata (0 for stores) into the result register and go to RESP.
- RESP (T+2+MEM_LAT): pulse the granted requester's res_valid with the registered data. This is a same-cycle IDLE arbitration, so a new handshake is allowed in this cycle.
- Throughput is one transaction per MEM_LAT+2 cycles.

Other rules:
- mem_* outputs are 0 in every state except ISSUE.
- Requesters hold valid and payload stable until ready. Deasserting valid before ready is legal and aborts that request with no side effects.
- Fixed-priority arbitration (default):
  - Data beats fetch.
  - starve_cnt increments in each IDLE cycle where fetch is valid and loses. It saturates at STARVE_MAX.
  - When starve_cnt==STARVE_MAX, fetch wins the next arbitration. starve_cnt clears on any fetch grant.
- Only one res_valid is ever high in a cycle. Both are never high simultaneously.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-grant pointer replaces starve_cnt. On contention, the requester not granted last wins. The pointer updates on every grant. STARVE_MAX is ignored.
- Undefined: fixed priority with starvation counter as above. The round-robin pointer logic is absent.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - requester enum {REQ_FETCH, REQ_DATA}
  - packed struct mem_txn_t {id, write, addr, wdata}
  - localparam LAT_CNT_W = 3
- Sub-module mem_arb_grant: combinational winner selection from both valids plus either starve_cnt or the round-robin pointer. The FSM, counters and registers stay in mem_port_arbiter.

Test Plan:
- MEM_LAT=1. Fetch-only load of 0x100, memory holds 0x00000013 at 0x100, handshake T=0 -> mem_en=1/mem_addr=0x100 at T=1; fetch_res_valid=1 with data 0x00000013 at T=3; fetch_req_ready=1 again at T=3.
- Store 0x200←0xDEADBEEF, then load 0x200 -> mem_we=1/mem_wdata=0xDEADBEEF at T+1; data_res_valid with rdata 0 at T+3; load returns 0xDEADBEEF.
- Fetch and data valid together in IDLE -> data_req_ready=1, fetch_req_ready=0; fetch is granted in the next transaction when data deasserts.
- Data valid continuously, fetch valid, STARVE_MAX=4 -> data wins 4 arbitrations, fetch wins the 5th, then starve_cnt=0.
- RESET pulsed during WAIT (MEM_LAT=3) -> all outputs 0 immediately; no res_valid afterwards; ready=1 in the first cycle after deassert with a valid request.
- MEM_ARB_ROUND_ROBIN_EN defined, both valid continuously -> grants alternate data, fetch, data, fetch, starting with data after reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, requester ids and the
// latched transaction record.
package mem_arb_pkg;

  localparam int LAT_CNT_W  = 3;
  localparam int STARVE_W   = 4;
  localparam int TXN_ADDR_W = 32;
  localparam int TXN_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef enum logic {REQ_FETCH, REQ_DATA} requester_t;

  typedef struct packed {
    requester_t            id;
    logic                  write;
    logic [TXN_ADDR_W-1:0] addr;
    logic [TXN_DATA_W-1:0] wdata;
  } mem_txn_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner selection between fetch and load/store requesters.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority with starvation relief.
module mem_arb_grant
  import mem_arb_pkg::*;
`ifndef MEM_ARB_ROUND_ROBIN_EN
#(
  parameter int STARVE_MAX = 4
)
`endif
(
  input  logic                fetch_valid,
  input  logic                data_valid,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic                last_grant,
`else
  input  logic [STARVE_W-1:0] starve_cnt,
`endif
  output logic                grant_fetch,
  output logic                grant_data
);

  logic fetch_first;

  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On contention the requester that did not win last time goes first.
    fetch_first = (last_grant == REQ_DATA);
`else
    // Data normally beats fetch, unless fetch has lost too many times in a row.
    fetch_first = (starve_cnt == STARVE_W'(STARVE_MAX));
`endif
    grant_fetch = fetch_valid && (!data_valid || fetch_first);
    grant_data  = data_valid && !grant_fetch;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory data port between instruction fetch and load/store, one
// transaction in flight. Optional MEM_ARB_ROUND_ROBIN_EN swaps in round-robin arbitration.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              fetch_req_valid,
  input  logic [ADDR_W-1:0] fetch_req_addr,
  output logic              fetch_req_ready,
  output logic              fetch_res_valid,
  output logic [DATA_W-1:0] fetch_res_data,
  input  logic              data_req_valid,
  input  logic              data_req_write,
  input  logic [ADDR_W-1:0] data_req_addr,
  input  logic [DATA_W-1:0] data_req_wdata,
  output logic              data_req_ready,
  output logic              data_res_valid,
  output logic [DATA_W-1:0] data_res_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a request transfers in any cycle where its valid and ready are
  // both high; ready is only offered in IDLE/RESP and only to the winner.
  state_t               state_q, state_d;
  mem_txn_t             txn_q, txn_d;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]    res_data_q, res_data_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  requester_t           last_grant_q, last_grant_d;
`else
  logic [STARVE_W-1:0]  starve_q, starve_d;
`endif

  logic grant_fetch, grant_data;
  logic arb_phase, fetch_hs, data_hs, issue;

  mem_arb_grant
`ifndef MEM_ARB_ROUND_ROBIN_EN
    #(.STARVE_MAX(STARVE_MAX))
`endif
  u_grant (
    .fetch_valid (fetch_req_valid),
    .data_valid  (data_req_valid),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_grant  (last_grant_q),
`else
    .starve_cnt  (starve_q),
`endif
    .grant_fetch (grant_fetch),
    .grant_data  (grant_data)
  );

  always_comb begin
    arb_phase = (state_q == IDLE) || (state_q == RESP);
    // Ready is masked while RESET is held so every output reads 0 in reset.
    fetch_hs  = arb_phase && grant_fetch && !RESET;
    data_hs   = arb_phase && grant_data && !RESET;

    state_d    = state_q;
    txn_d      = txn_q;
    lat_cnt_d  = lat_cnt_q;
    res_data_d = res_data_q;

    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (fetch_hs || data_hs) begin
          txn_d.id    = data_hs ? REQ_DATA : REQ_FETCH;
          txn_d.write = data_hs && data_req_write;
          txn_d.addr  = data_hs ? TXN_ADDR_W'(data_req_addr) : TXN_ADDR_W'(fetch_req_addr);
          txn_d.wdata = (data_hs && data_req_write) ? TXN_DATA_W'(data_req_wdata) : '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        lat_cnt_d = LAT_CNT_W'(MEM_LAT);
        state_d   = WAIT;
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
        if (lat_cnt_q == LAT_CNT_W'(1)) begin
          res_data_d = txn_q.write ? '0 : mem_rdata;
          state_d    = RESP;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
    if (fetch_hs)     last_grant_d = REQ_FETCH;
    else if (data_hs) last_grant_d = REQ_DATA;
`else
    starve_d = starve_q;
    if (fetch_hs) begin
      starve_d = '0;
    end else if (data_hs && fetch_req_valid && starve_q != STARVE_W'(STARVE_MAX)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      txn_q        <= '0;
      lat_cnt_q    <= '0;
      res_data_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= REQ_FETCH;
`else
      starve_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      txn_q        <= txn_d;
      lat_cnt_q    <= lat_cnt_d;
      res_data_q   <= res_data_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`else
      starve_q     <= starve_d;
`endif
    end
  end

  // Memory strobes and responses are decoded from registered state only.
  always_comb begin
    issue           = (state_q == ISSUE);
    mem_en          = issue;
    mem_we          = issue && txn_q.write;
    mem_addr        = issue ? ADDR_W'(txn_q.addr) : '0;
    mem_wdata       = (issue && txn_q.write) ? DATA_W'(txn_q.wdata) : '0;
    fetch_res_valid = (state_q == RESP) && (txn_q.id == REQ_FETCH);
    data_res_valid  = (state_q == RESP) && (txn_q.id == REQ_DATA);
    fetch_res_data  = fetch_res_valid ? res_data_q : '0;
    data_res_rdata  = data_res_valid ? res_data_q : '0;
    fetch_req_ready = fetch_hs;
    data_req_ready  = data_hs;
    dbg_state       = state_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic, checked against a timestamp-based transaction model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT  = 3;
  localparam int SMAX = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        fetch_req_valid, fetch_req_ready, fetch_res_valid;
  logic [31:0] fetch_req_addr, fetch_res_data;
  logic        data_req_valid, data_req_write, data_req_ready, data_res_valid;
  logic [31:0] data_req_addr, data_req_wdata, data_res_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .CLK(clk), .RESET(rst),
    .fetch_req_valid(fetch_req_valid), .fetch_req_addr(fetch_req_addr),
    .fetch_req_ready(fetch_req_ready), .fetch_res_valid(fetch_res_valid),
    .fetch_res_data(fetch_res_data),
    .data_req_valid(data_req_valid), .data_req_write(data_req_write),
    .data_req_addr(data_req_addr), .data_req_wdata(data_req_wdata),
    .data_req_ready(data_req_ready), .data_res_valid(data_res_valid),
    .data_res_rdata(data_res_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // scoreboard / model state
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int issue_cyc = -1, resp_cyc = -1, free_cyc = 0, rd_due = -1;
  int starve   = 0;
  logic rr_last = 1'b0;
  logic        m_is_data = 1'b0, m_write = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_res = '0, rd_val = '0;
  logic [31:0] mem_a [logic [31:0]];
  logic        gnt_obs[$];
  logic [0:0]  exp_q[$];

  // requester stimulus state
  logic        f_v = 1'b0, d_v = 1'b0, d_w = 1'b0;
  logic [31:0] f_a = '0, d_a = '0, d_wd = '0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_a.exists(a)) return mem_a[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    base = ($urandom_range(0, 1) == 1) ? 32'h200 : 32'h100;
    return base + ($urandom_range(0, 7) << 2);
  endfunction

  task automatic model_reset();
    issue_cyc = -1;
    resp_cyc  = -1;
    rd_due    = -1;
    free_cyc  = cyc;
    starve    = 0;
    rr_last   = 1'b0;
  endtask

  task automatic check_zero();
    check_eq("rst_res", {fetch_req_ready, fetch_res_valid, fetch_res_data,
                         data_req_ready, data_res_valid, data_res_rdata}, '0);
    check_eq("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, '0);
    check_eq("rst_state", dbg_state, IDLE);
  endtask

  // registered outputs of the current cycle, plus the memory model
  task automatic step_outputs();
    logic [65:0] exp_bus;
    @(posedge clk); #1;
    cyc++;
    exp_bus = '0;
    if (cyc == issue_cyc) begin
      exp_bus = {1'b1, m_write, m_addr, m_write ? m_wdata : 32'h0};
      rd_val  = m_write ? $urandom() : mem_rd(m_addr);
      m_res   = m_write ? 32'h0 : rd_val;
      if (m_write) mem_a[m_addr] = m_wdata;
      rd_due  = cyc + LAT;
    end
    check_eq("mem_bus", {mem_en, mem_we, mem_addr, mem_wdata}, exp_bus);
    check_eq("fetch_res_valid", fetch_res_valid, (cyc == resp_cyc) && !m_is_data);
    check_eq("data_res_valid", data_res_valid, (cyc == resp_cyc) && m_is_data);
    if (cyc == resp_cyc) begin
      if (m_is_data) check_eq("data_res_rdata", data_res_rdata, m_res);
      else           check_eq("fetch_res_data", fetch_res_data, m_res);
    end
    mem_rdata = (cyc == rd_due) ? rd_val : $urandom();
  endtask

  // drive requests, check combinational ready, advance the model on a grant
  task automatic step_arb();
    logic fwin, exp_fr, exp_dr;
    fetch_req_valid = f_v;
    fetch_req_addr  = f_a;
    data_req_valid  = d_v;
    data_req_write  = d_w;
    data_req_addr   = d_a;
    data_req_wdata  = d_wd;
    #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    fwin = f_v && (!d_v || rr_last);
`else
    fwin = f_v && (!d_v || starve == SMAX);
`endif
    exp_fr = (cyc >= free_cyc) && fwin;
    exp_dr = (cyc >= free_cyc) && d_v && !fwin;
    check_eq("fetch_req_ready", fetch_req_ready, exp_fr);
    check_eq("data_req_ready", data_req_ready, exp_dr);
    if (fetch_req_ready || data_req_ready) gnt_obs.push_back(data_req_ready);
    if (exp_fr || exp_dr) begin
      m_is_data = exp_dr;
      m_write   = exp_dr && d_w;
      m_addr    = exp_dr ? d_a : f_a;
      m_wdata   = d_wd;
      issue_cyc = cyc + 1;
      resp_cyc  = cyc + 2 + LAT;
      free_cyc  = resp_cyc;
      if (exp_fr) starve = 0;
      else if (f_v && starve < SMAX) starve++;
      rr_last = exp_dr;
      if (exp_fr) f_v = 1'b0;
      else        d_v = 1'b0;
    end
  endtask

  task automatic step();
    step_outputs();
    step_arb();
  endtask

  task automatic pulse_reset(input int hold);
    rst = 1'b1;
    #1;
    check_zero();
    repeat (hold) begin
      @(posedge clk); #1;
      cyc++;
      check_zero();
    end
    rst = 1'b0;
    model_reset();
    step_arb();
  endtask

  task automatic gen_reqs();
    if (!f_v) begin
      if ($urandom_range(0, 2) == 0) begin f_v = 1'b1; f_a = rand_addr(); end
    end else if ($urandom_range(0, 19) == 0) f_v = 1'b0;
    if (!d_v) begin
      if ($urandom_range(0, 2) == 0) begin
        d_v = 1'b1; d_w = 1'($urandom_range(0, 1)); d_a = rand_addr(); d_wd = $urandom();
      end
    end else if ($urandom_range(0, 19) == 0) d_v = 1'b0;
  endtask

  initial begin
    int budget;
    fetch_req_valid = 0; fetch_req_addr = 0;
    data_req_valid = 0; data_req_write = 0; data_req_addr = 0; data_req_wdata = 0;
    mem_rdata = 0;
    @(posedge clk); #1;
    cyc++;
    pulse_reset(2);

    // single fetch, then a back-to-back fetch that must wait MEM_LAT+2 cycles
    mem_a[32'h100] = 32'h0000_0013;
    f_v = 1'b1; f_a = 32'h100; step();
    f_v = 1'b1; f_a = 32'h104;
    repeat (2 * LAT + 6) step();

    // store then load of the same word
    d_v = 1'b1; d_w = 1'b1; d_a = 32'h200; d_wd = 32'hDEAD_BEEF; step();
    d_v = 1'b1; d_w = 1'b0; d_a = 32'h200;
    repeat (2 * LAT + 6) step();

    // contention: data first, fetch next
    f_v = 1'b1; f_a = 32'h108; d_v = 1'b1; d_w = 1'b0; d_a = 32'h204;
    repeat (2 * LAT + 8) step();

    // sustained contention straight after reset
    f_v = 1'b0; d_v = 1'b0;
    pulse_reset(2);
    gnt_obs.delete();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
    budget = 200;
    while (gnt_obs.size() < exp_q.size() && budget > 0) begin
      f_v = 1'b1; f_a = 32'h10C;
      if (!d_v) begin d_v = 1'b1; d_w = 1'b0; d_a = rand_addr(); end
      step();
      budget--;
    end
    check_eq("grant_count", gnt_obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < gnt_obs.size(); i++)
      check_eq("grant_seq", gnt_obs[i], exp_q[i]);
    f_v = 1'b0; d_v = 1'b0;
    repeat (2 * LAT + 6) step();

    // reset while a load is in WAIT; fetch waits across the reset
    d_v = 1'b1; d_w = 1'b0; d_a = 32'h100; step();
    step(); step();
    f_v = 1'b1; f_a = 32'h110;
    pulse_reset(1);
    repeat (2 * LAT + 8) step();

    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      gen_reqs();
      step();
      if (i % 500 == 250) pulse_reset(1 + $urandom_range(0, 2));
    end
    f_v = 1'b0; d_v = 1'b0;
    repeat (2 * LAT + 6) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
